dram_req_master: RTL and testbench

//  Requester-side counterpart of the DRAM top interface: drives dREN/dWEN/ram_addr/ramstore and consumes ramload/ram_wait.

---
 rtl/dram_req_master.sv | 172 +++++++++++++++++
 tb/tb_dram_req_master.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_req_master.sv
// dram_req_master: queues client read/write requests in a small FIFO and
// issues them one at a time on the DRAM dREN/dWEN/ram_addr/ramstore port.
// Read data comes back through a valid/ready port and writes end with a
// one-cycle wr_done pulse. A sticky timeout_err flags an access that has
// waited TIMEOUT_CYCLES cycles.
module dram_req_master #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              wr_done,
  output logic              dREN,
  output logic              dWEN,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_wait,
  output logic              busy,
  output logic              timeout_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic              r_fifoWen  [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_fifoAddr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifoWdata[FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;

  logic              r_curWen;
  logic [ADDR_W-1:0] r_curAddr;
  logic [DATA_W-1:0] r_curWdata;
  logic [DATA_W-1:0] r_rspRdata;
  logic              r_wrDone;
  logic [TO_W-1:0]   r_waitCnt;
  logic              r_timeoutErr;

  logic w_push;
  logic w_pop;
  logic w_done;

  // req_ready only looks at the registered count, so a full FIFO that pops
  // this cycle still refuses the incoming request.
  assign req_ready = (r_count != CNT_W'(FIFO_DEPTH));
  assign w_push    = req_valid && req_ready;
  assign w_pop     = (r_state == IDLE) && (r_count != '0);
  assign w_done    = (r_state == BUSY) && !ram_wait;

  assign ram_addr    = r_curAddr;
  assign ramstore    = r_curWdata;
  assign rsp_rdata   = r_rspRdata;
  assign wr_done     = r_wrDone;
  assign timeout_err = r_timeoutErr;
  assign busy        = (r_state != IDLE) || (r_count != '0);

  // FIFO payload storage; no reset needed because the pointers define validity
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_fifoWen[r_wrPtr]   <= req_wen;
      r_fifoAddr[r_wrPtr]  <= req_addr;
      r_fifoWdata[r_wrPtr] <= req_wdata;
    end
  end

  // FIFO pointers and occupancy; reset drops every queued request
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FSM next-state and DRAM strobes; strobes are only ever high in BUSY
  always_comb begin
    w_nextState = r_state;
    dREN        = 1'b0;
    dWEN        = 1'b0;
    rsp_valid   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pop) w_nextState = BUSY;
      end
      BUSY: begin
        dREN = !r_curWen;
        dWEN = r_curWen;
        if (!ram_wait) w_nextState = r_curWen ? IDLE : RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Latch the FIFO head as the current access; it stays put until the next pop
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_curWen   <= 1'b0;
      r_curAddr  <= '0;
      r_curWdata <= '0;
    end else if (w_pop) begin
      r_curWen   <= r_fifoWen[r_rdPtr];
      r_curAddr  <= r_fifoAddr[r_rdPtr];
      r_curWdata <= r_fifoWdata[r_rdPtr];
    end
  end

  // Capture read data on completion and pulse wr_done after a write completes
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rspRdata <= '0;
      r_wrDone   <= 1'b0;
    end else begin
      r_wrDone <= w_done && r_curWen;
      if (w_done && !r_curWen) r_rspRdata <= ramload;
    end
  end

  // Count wait cycles of the current access; the error is sticky and the access is never aborted
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_waitCnt    <= '0;
      r_timeoutErr <= 1'b0;
    end else if (w_pop) begin
      r_waitCnt <= '0;
    end else if ((r_state == BUSY) && ram_wait) begin
      if (r_waitCnt < TO_W'(TIMEOUT_CYCLES)) begin
        r_waitCnt <= r_waitCnt + TO_W'(1);
        if (r_waitCnt == TO_W'(TIMEOUT_CYCLES - 1)) r_timeoutErr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dram_req_master.sv
// tb_dram_req_master: random and directed traffic into dram_req_master with a
// behavioural DRAM responder and a scoreboard of expected DRAM accesses and
// read responses built from the request stream.
module tb_dram_req_master;

  logic        CLK;
  logic        nRST;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        wr_done;
  logic        dREN;
  logic        dWEN;
  logic [31:0] ram_addr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_wait;
  logic        busy;
  logic        timeout_err;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t        expReq[$];
  logic [31:0] expRsp[$];
  logic [31:0] refMem  [logic [31:0]];
  logic [31:0] dramMem [logic [31:0]];

  int compareCount  = 0;
  int mismatchCount = 0;
  int acceptCount   = 0;
  int accessCount   = 0;
  int rspCount      = 0;
  int wrDoneCount   = 0;
  int lastLen       = 0;

  logic holdWait = 1'b0;
  int   fixedK   = 0;

  dram_req_master #(
    .FIFO_DEPTH(4), .TIMEOUT_CYCLES(1024), .ADDR_W(32), .DATA_W(32)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .wr_done(wr_done),
    .dREN(dREN), .dWEN(dWEN), .ram_addr(ram_addr), .ramstore(ramstore),
    .ramload(ramload), .ram_wait(ram_wait),
    .busy(busy), .timeout_err(timeout_err)
  );

  // Free-running clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Global watchdog so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] defaultWord(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] refLookup(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : defaultWord(a);
  endfunction

  function automatic logic [31:0] dramLookup(input logic [31:0] a);
    return dramMem.exists(a) ? dramMem[a] : defaultWord(a);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(posedge CLK);
    #1;
    req_valid = v;
    req_wen   = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic waitIdle(input int maxCycles);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while ((busy || expReq.size() != 0 || expRsp.size() != 0) && n < maxCycles);
    checkOutput("drain_complete", {busy, expReq.size() != 0, expRsp.size() != 0}, 3'b000);
    repeat (2) @(negedge CLK);
  endtask

  // DRAM responder: stalls each access for K cycles and serves reads from its own memory
  initial begin
    int accCyc;
    int curK;
    accCyc   = 0;
    curK     = 0;
    ram_wait = 1'b1;
    ramload  = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (holdWait) begin
        ram_wait = 1'b1;
        accCyc   = 0;
      end else if (dREN || dWEN) begin
        if (accCyc == 0) curK = (fixedK >= 0) ? fixedK : int'($urandom_range(0, 3));
        ram_wait = (accCyc < curK);
        accCyc++;
      end else begin
        accCyc   = 0;
        ram_wait = 1'($urandom_range(0, 1));
      end
      ramload = dramLookup(ram_addr);
    end
  end

  // Request acceptance: push the expected access and any expected read data
  initial begin
    forever begin
      @(negedge CLK);
      if (nRST && req_valid && req_ready) begin
        expReq.push_back('{wen: req_wen, addr: req_addr, wdata: req_wdata});
        if (req_wen) refMem[req_addr] = req_wdata;
        else expRsp.push_back(refLookup(req_addr));
        acceptCount++;
      end
    end
  end

  // DRAM-side monitor: access order, stability, exclusivity, gaps and wr_done timing
  initial begin
    logic prevActive;
    logic prevCompleting;
    logic prevWasWrite;
    logic active;
    logic completing;
    req_t cur;
    int   curLen;
    prevActive     = 1'b0;
    prevCompleting = 1'b0;
    prevWasWrite   = 1'b0;
    cur            = '0;
    curLen         = 0;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        prevActive     = 1'b0;
        prevCompleting = 1'b0;
        prevWasWrite   = 1'b0;
      end else begin
        active = dREN || dWEN;
        checkOutput("strobe_exclusive", dREN && dWEN, 1'b0);
        if (prevCompleting) checkOutput("idle_gap", active, 1'b0);
        if (active && !prevActive) begin
          accessCount++;
          curLen = 0;
          checkOutput("access_expected", expReq.size() != 0, 1'b1);
          if (expReq.size() != 0) begin
            cur = expReq.pop_front();
            checkOutput("access_wen", dWEN, cur.wen);
            checkOutput("access_addr", ram_addr, cur.addr);
            if (cur.wen) checkOutput("access_wdata", ramstore, cur.wdata);
          end
        end else if (active) begin
          checkOutput("stable_addr", ram_addr, cur.addr);
          checkOutput("stable_wen", dWEN, cur.wen);
        end
        if (active) curLen++;
        completing = active && !ram_wait;
        if (completing) begin
          lastLen = curLen;
          if (dWEN) dramMem[ram_addr] = ramstore;
        end
        checkOutput("wr_done", wr_done, prevCompleting && prevWasWrite);
        if (wr_done) wrDoneCount++;
        prevActive     = active && !completing;
        prevCompleting = completing;
        prevWasWrite   = dWEN;
      end
    end
  end

  // Response monitor: every rsp handshake must match the next expected read data
  initial begin
    forever begin
      @(negedge CLK);
      if (nRST && rsp_valid && rsp_ready) begin
        rspCount++;
        checkOutput("rsp_expected", expRsp.size() != 0, 1'b1);
        if (expRsp.size() != 0) checkOutput("rsp_rdata", rsp_rdata, expRsp.pop_front());
      end
    end
  end

  // Main sequence: reset, directed scenarios, random traffic, timeout, reset mid-access
  initial begin
    int          accBefore;
    int          rspBefore;
    int          wrBefore;
    int          n;
    logic        readyAtSixth;
    logic [31:0] expData;

    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    nRST      = 1'b1;
    readyAtSixth = 1'b1;
    #1 nRST = 1'b0;
    repeat (2) @(negedge CLK);
    checkOutput("rst_req_ready", req_ready, 1'b1);
    checkOutput("rst_strobes", {dREN, dWEN}, 2'b00);
    checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
    checkOutput("rst_wr_done", wr_done, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_timeout", timeout_err, 1'b0);
    checkOutput("rst_ram_addr", ram_addr, 32'h0);
    checkOutput("rst_ramstore", ramstore, 32'h0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
    @(posedge CLK);
    #1 nRST = 1'b1;

    // Directed read: three wait cycles then completion
    refMem[32'h100]  = 32'hDEADBEEF;
    dramMem[32'h100] = 32'hDEADBEEF;
    fixedK    = 3;
    rspBefore = rspCount;
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    waitIdle(50);
    checkOutput("read_dren_cycles", lastLen, 4);
    checkOutput("read_rsp_count", rspCount - rspBefore, 1);

    // Directed write: single-cycle access
    fixedK    = 0;
    rspBefore = rspCount;
    wrBefore  = wrDoneCount;
    applyStimulus(1'b1, 1'b1, 32'h200, 32'hCAFEF00D);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    waitIdle(50);
    checkOutput("write_dwen_cycles", lastLen, 1);
    checkOutput("write_done_pulses", wrDoneCount - wrBefore, 1);
    checkOutput("write_no_rsp", rspCount - rspBefore, 0);
    checkOutput("write_dram_data", dramLookup(32'h200), 32'hCAFEF00D);

    // Full: one stalled access plus four queued, sixth push refused
    holdWait  = 1'b1;
    accBefore = acceptCount;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, i[0], 32'h300 + 32'(4 * i), 32'h1000 + 32'(i));
      @(negedge CLK);
      if (i == 5) readyAtSixth = req_ready;
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("full_accepted", acceptCount - accBefore, 5);
    checkOutput("full_ready_sixth", readyAtSixth, 1'b0);
    @(negedge CLK);
    checkOutput("full_ready_held", req_ready, 1'b0);
    holdWait = 1'b0;
    fixedK   = 0;
    waitIdle(100);

    // Backpressure: read response held while two requests sit in the FIFO
    rsp_ready = 1'b0;
    expData   = refLookup(32'h400);
    applyStimulus(1'b1, 1'b0, 32'h400, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h404, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h408, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("bp_rsp_arrived", rsp_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checkOutput("bp_valid_held", rsp_valid, 1'b1);
      checkOutput("bp_no_dram", {dREN, dWEN}, 2'b00);
      checkOutput("bp_rdata", rsp_rdata, expData);
      checkOutput("bp_busy", busy, 1'b1);
    end
    @(posedge CLK);
    #1 rsp_ready = 1'b1;
    waitIdle(100);

    // Random traffic with random stalls and random response backpressure
    fixedK = -1;
    for (int c = 0; c < 400; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    32'h100 + 32'(4 * $urandom_range(0, 7)), $urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    rsp_ready = 1'b1;
    waitIdle(500);

    // Timeout: one read stalled for 1100 cycles
    checkOutput("timeout_clear_before", timeout_err, 1'b0);
    fixedK = 1100;
    applyStimulus(1'b1, 1'b0, 32'h500, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!dREN && n < 10);
    checkOutput("timeout_access_started", dREN, 1'b1);
    repeat (1023) @(negedge CLK);
    checkOutput("timeout_before_1024", timeout_err, 1'b0);
    @(negedge CLK);
    checkOutput("timeout_at_1024", timeout_err, 1'b1);
    waitIdle(300);
    checkOutput("timeout_sticky", timeout_err, 1'b1);
    fixedK = 0;

    // Reset in the middle of a stalled access with another request queued
    holdWait = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h600, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h604, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    n = 0;
    while (!dREN && n < 10) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("mid_access_started", dREN, 1'b1);
    @(posedge CLK);
    #3 nRST = 1'b0;
    #1;
    checkOutput("mid_rst_strobes", {dREN, dWEN}, 2'b00);
    checkOutput("mid_rst_req_ready", req_ready, 1'b1);
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_timeout", timeout_err, 1'b0);
    checkOutput("mid_rst_ram_addr", ram_addr, 32'h0);
    expReq.delete();
    expRsp.delete();
    repeat (2) @(posedge CLK);
    holdWait = 1'b0;
    #1 nRST = 1'b1;
    accBefore = accessCount;
    repeat (10) @(negedge CLK);
    checkOutput("no_stale_access", accessCount - accBefore, 0);
    checkOutput("post_rst_ready", req_ready, 1'b1);
    checkOutput("post_rst_busy", busy, 1'b0);

    checkOutput("final_req_queue", expReq.size(), 0);
    checkOutput("final_rsp_queue", expRsp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
